bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the 7-segment serial driver. It accepts a 16-bit binary value through a valid/ready handshake and presents four registered BCD digits plus an overflow flag. The digits hold stable between conversions so the driver can scan them continuously.

---
 rtl/bin_to_bcd_seq_pkg.sv | 22 ++
 rtl/bin_to_bcd_seq_add3.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 180 ++++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq_pkg
// Shared definitions for the sequential binary-to-BCD converter and the
// downstream 7-segment decoder:
//   IN_W_DEF / NDIG_DEF : default binary width and internal BCD digit count
//   state_t             : converter FSM encoding
//   BLANK_DIGIT         : digit code the 7-seg decoder renders as all segments off
// -----------------------------------------------------------------------------
package bin_to_bcd_seq_pkg;

    localparam int IN_W_DEF = 16;
    localparam int NDIG_DEF = 5;   // 10^5 > 2^16 - 1

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3_cell
// Combinational double-dabble correction for one BCD digit: a digit of 5 or
// more gets +3 so that the following left shift carries correctly into the
// next decade.
// Ports:
//   d : 4-bit BCD digit before correction
//   q : corrected digit (d >= 5 ? d + 3 : d)
// -----------------------------------------------------------------------------
module bcd_add3_cell (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. A value is accepted through a valid/ready handshake in IDLE, shifted
// for IN_W cycles in SHIFT, and published in DONE. The four output digits and
// the overflow flag are registered and only change in DONE, so a display
// driver can scan them continuously.
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : bin is valid this cycle
//   in_ready  : high only in IDLE
//   bin       : binary value to convert
//   out_valid : one-cycle pulse when new digits are written
//   bcd0..3   : ones, tens, hundreds, thousands digits
//   ovf       : value > 9999 (a digit above bcd3 is nonzero)
//   busy      : conversion in progress (state != IDLE)
//
// Build option:
//   LEADING_ZERO_BLANK_EN : when defined, leading zero digits bcd3..bcd1 are
//                           replaced by BLANK_DIGIT (never when ovf is set);
//                           bcd0 is never blanked.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int IN_W = IN_W_DEF,
    parameter int NDIG = NDIG_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] bin,
    output logic            out_valid,
    output logic [3:0]      bcd0,
    output logic [3:0]      bcd1,
    output logic [3:0]      bcd2,
    output logic [3:0]      bcd3,
    output logic            ovf,
    output logic            busy
);

    localparam int ACC_W = NDIG * 4;
    localparam int CAT_W = ACC_W + IN_W;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    state_t           state_q, state_d;
    logic [IN_W-1:0]  shreg_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_adj;
    logic [CAT_W-1:0] shifted;
    logic [CNT_W-1:0] cnt_q;
    logic             load, shift_en, done;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, independent of
    // process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = ~in_ready;

    // ----------------------------------------------------------- datapath
    // Add-3 correction on every digit, applied before each shift (including
    // the first, where it is a no-op on the cleared accumulator).
    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        bcd_add3_cell u_add3 (
            .d (acc_q[g*4 +: 4]),
            .q (acc_adj[g*4 +: 4])
        );
    end

    // {accumulator, shift register} moves left as one word; the top bit falls
    // off, which is safe because NDIG is sized so the top digit never reaches 8.
    assign shifted = {acc_adj, shreg_q} << 1;

    // NOTE: the working registers are plain flops, not a memory, so they are
    // cleared on reset; an aborted conversion then leaves no stale state.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shreg_q <= bin;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            acc_q   <= shifted[CAT_W-1:IN_W];
            shreg_q <= shifted[IN_W-1:0];
            if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------ output digits
    logic [3:0] raw0, raw1, raw2, raw3;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic       ovf_w;

    assign raw0  = acc_q[3:0];
    assign raw1  = acc_q[7:4];
    assign raw2  = acc_q[11:8];
    assign raw3  = acc_q[15:12];
    assign ovf_w = |acc_q[ACC_W-1:16];

`ifdef LEADING_ZERO_BLANK_EN
    logic blank1, blank2, blank3;

    // Blanking runs from the most significant digit down and stops at the
    // first nonzero digit; an overflowed value is shown unblanked.
    always_comb begin
        blank3 = ~ovf_w && (raw3 == 4'd0);
        blank2 = blank3 && (raw2 == 4'd0);
        blank1 = blank2 && (raw1 == 4'd0);
        dig0   = raw0;
        dig1   = blank1 ? BLANK_DIGIT : raw1;
        dig2   = blank2 ? BLANK_DIGIT : raw2;
        dig3   = blank3 ? BLANK_DIGIT : raw3;
    end
`else
    assign dig0 = raw0;
    assign dig1 = raw1;
    assign dig2 = raw2;
    assign dig3 = raw3;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            bcd0      <= '0;
            bcd1      <= '0;
            bcd2      <= '0;
            bcd3      <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= done;
            if (done) begin
                bcd0 <= dig0;
                bcd1 <= dig1;
                bcd2 <= dig2;
                bcd3 <= dig3;
                ovf  <= ovf_w;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Directed bench for bin_to_bcd_seq. Expected digits come from a decimal
// arithmetic model and are queued at the handshake together with the edge on
// which the result must appear; a monitor pops and compares on out_valid.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int IN_W = 16;
    localparam int LAT  = IN_W + 1;   // accept edge -> edge that raises out_valid

    typedef struct {
        logic [16:0] exp;
        int          due;
        int          val;
    } item_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] bin;
    logic            out_valid;
    logic [3:0]      bcd0, bcd1, bcd2, bcd3;
    logic            ovf;
    logic            busy;
    logic [16:0]     obs_disp;

    item_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    bin_to_bcd_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .bcd0      (bcd0),
        .bcd1      (bcd1),
        .bcd2      (bcd2),
        .bcd3      (bcd3),
        .ovf       (ovf),
        .busy      (busy)
    );

    assign obs_disp = {ovf, bcd3, bcd2, bcd1, bcd0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal model: {ovf, d3, d2, d1, d0} as the display should show it.
    function automatic logic [16:0] model(input int v);
        logic [3:0] d0, d1, d2, d3;
        logic       o;
        d0 = 4'(v % 10);
        d1 = 4'((v / 10) % 10);
        d2 = 4'((v / 100) % 10);
        d3 = 4'((v / 1000) % 10);
        o  = (v > 9999);
`ifdef LEADING_ZERO_BLANK_EN
        if (!o && d3 == 4'd0) begin
            d3 = 4'hF;
            if (d2 == 4'd0) begin
                d2 = 4'hF;
                if (d1 == 4'd0) d1 = 4'hF;
            end
        end
`endif
        return {o, d3, d2, d1, d0};
    endfunction

    // Result monitor: sampled 1 time unit after the rising edge.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_out_valid: observed=%0h expected=no pulse at edge %0d",
                       obs_disp, cyc);
            end
            if (sb.size() != 0) begin
                item_t it;
                it = sb.pop_front();
                check($sformatf("digits_%0d", it.val), 32'(obs_disp), 32'(it.exp));
                check($sformatf("latency_%0d", it.val), 32'(cyc), 32'(it.due));
            end
        end
    end

    // Drive one value and hold in_valid until the handshake; queue the result.
    task automatic send(input int v);
        bit ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        bin      = IN_W'(v);
        for (int i = 0; i < 60 && !ok; i++) begin
            if (in_ready === 1'b1) begin
                sb.push_back('{exp: model(v), due: cyc + 1 + LAT, val: v});
                ok = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout_%0d: observed=in_ready low expected=accept", v);
        end
    endtask

    // Wait (bounded) until every queued result has been observed.
    task automatic drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: observed=%0d pending expected=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc_cnt;
        int acc_edge [2];

        rst      = 1'b1;
        in_valid = 1'b0;
        bin      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_digits", 32'(obs_disp), 32'd0);

        // Basic conversions
        send(0);
        drain();

        send(1234);
        n = 0;
        while (in_ready === 1'b0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("ready_low_cycles", 32'(n), 32'd17);
        drain();

        send(9999);  drain();
        send(10000); drain();
        send(65535); drain();

        // in_valid held high: 42 then 7, accepts back-to-back
        @(negedge clk);
        in_valid = 1'b1;
        bin      = IN_W'(42);
        acc_cnt  = 0;
        acc_edge = '{0, 0};
        for (int i = 0; i < 80 && acc_cnt < 2; i++) begin
            if (in_ready === 1'b1) begin
                sb.push_back('{exp: model(int'(bin)), due: cyc + 1 + LAT, val: int'(bin)});
                acc_edge[acc_cnt] = cyc + 1;
                acc_cnt++;
            end
            @(negedge clk);
            if (acc_cnt == 1) bin = IN_W'(7);
        end
        in_valid = 1'b0;
        check("held_accept_count", 32'(acc_cnt), 32'd2);
        check("held_accept_spacing", 32'(acc_edge[1] - acc_edge[0]), 32'd18);
        check("hold_between_done", 32'(obs_disp), 32'(model(42)));
        drain();
        check("after_second_done", 32'(obs_disp), 32'(model(7)));

        // Input change and in_valid pulse mid-SHIFT are ignored
        send(500);
        repeat (5) @(negedge clk);
        in_valid = 1'b1;
        bin      = IN_W'(999);
        @(negedge clk);
        check("midshift_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        drain();

        // Reset at SHIFT cycle 8, together with in_valid: abort, nothing accepted
        send(321);
        repeat (7) @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        bin      = IN_W'(77);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        void'(sb.pop_back());
        check("abort_digits", 32'(obs_disp), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        check("abort_idle_after", 32'(busy), 32'd0);
        check("abort_digits_after", 32'(obs_disp), 32'd0);

        // Values that exercise blanking/overflow interaction
        send(12345); drain();
        send(100);   drain();
        send(5);     drain();

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
